// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the fetch stage
package fetch_pkg;
  localparam int XLEN_DEF = 64;
  localparam int ILEN_DEF = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 21;
  localparam int PC_INC = 4;
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: branch target adder (resolve_pc + extimm*4) and taken-redirect condition
module next_pc_calc #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] resolve_pc,
  input  logic [XLEN-1:0] resolve_extimm,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  input  logic            resolve_valid,
  output logic [XLEN-1:0] target,
  output logic            redirect
);
  assign target = resolve_pc + (resolve_extimm << 2);
  assign redirect = resolve_valid & (uncond_branch | (branch & zero));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing imem requests, one-entry decode buffer, branch redirect with in-flight drain
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ILEN = ILEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             resetl,
  input  logic [XLEN-1:0]  startpc,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [ILEN-1:0]  instr,
  output logic [XLEN-1:0]  instr_pc,
  output logic [10:0]      opcode,
  input  logic             resolve_valid,
  input  logic [XLEN-1:0]  resolve_pc,
  input  logic [XLEN-1:0]  resolve_extimm,
  input  logic             branch,
  input  logic             uncond_branch,
  input  logic             zero,
  output logic [CNT_W-1:0] redirect_count
);
  state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, hold_q, hold_d, ipc_q, ipc_d, target;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, redirect_raw, rd, in_fetch, in_drain, capture;
  next_pc_calc #(.XLEN(XLEN)) u_npc (
    .resolve_pc(resolve_pc),
    .resolve_extimm(resolve_extimm),
    .branch(branch),
    .uncond_branch(uncond_branch),
    .zero(zero),
    .resolve_valid(resolve_valid),
    .target(target),
    .redirect(redirect_raw)
  );
  assign in_fetch = state_q == FETCH;
  assign in_drain = state_q == DRAIN;
  assign rd = redirect_raw & (state_q != BOOT);
  assign imem_req = in_drain | (in_fetch & (~valid_q | instr_ready));
  assign imem_addr = in_drain ? hold_q : pc_q;
  assign capture = in_fetch & imem_req & imem_ready & ~rd;
  assign instr_valid = valid_q;
  assign instr = instr_q;
  assign instr_pc = ipc_q;
  assign opcode = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign redirect_count = cnt_q;
  always_comb begin
    state_d = (state_q == BOOT) ? FETCH : (imem_req & ~imem_ready & (rd | in_drain)) ? DRAIN : FETCH;
    pc_d = (state_q == BOOT) ? startpc : rd ? target : capture ? pc_q + XLEN'(PC_INC) : pc_q;
    hold_d = (in_fetch & rd) ? pc_q : hold_q;
    valid_d = rd ? 1'b0 : capture ? 1'b1 : instr_ready ? 1'b0 : valid_q;
    instr_d = capture ? imem_rdata : instr_q;
    ipc_d = capture ? pc_q : ipc_q;
    cnt_d = cnt_q + CNT_W'(rd);
  end
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= BOOT;
      pc_q <= '0;
      hold_q <= '0;
      ipc_q <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      hold_q <= hold_d;
      ipc_q <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic CLK = 1'b0, resetl = 1'b0;
  logic [63:0] startpc = 64'h100, imem_addr, instr_pc, resolve_pc = '0, resolve_extimm = '0;
  logic imem_req, imem_ready = 1'b1, instr_valid, instr_ready = 1'b1;
  logic resolve_valid = 1'b0, branch = 1'b0, uncond_branch = 1'b0, zero = 1'b0;
  logic [31:0] imem_rdata, instr, redirect_count;
  logic [10:0] opcode;
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  function automatic logic [31:0] word(input logic [63:0] a);
    return {a[12:2], a[20:0]};
  endfunction
  assign imem_rdata = word(imem_addr);
  fetch_unit dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .opcode(opcode),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_extimm(resolve_extimm),
    .branch(branch), .uncond_branch(uncond_branch), .zero(zero), .redirect_count(redirect_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_buf(input string tag, input logic [63:0] pc);
    logic [31:0] w;
    w = word(pc);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, 64'(instr), 64'(w));
    chk({tag, "_opcode"}, 64'(opcode), 64'(w[31:21]));
  endtask
  task automatic resolve(input logic [63:0] pc, input logic [63:0] imm, input logic u, input logic b, input logic z);
    resolve_valid = 1'b1;
    resolve_pc = pc;
    resolve_extimm = imm;
    uncond_branch = u;
    branch = b;
    zero = z;
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", 64'(instr_valid), 0);
    chk("rst_instr", 64'(instr), 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_opcode", 64'(opcode), 0);
    chk("rst_cnt", 64'(redirect_count), 0);
    resetl = 1'b1;
    #1;
    chk("boot_req", 64'(imem_req), 0);
    tick();
    chk("f0_req", 64'(imem_req), 1);
    chk("f0_addr", imem_addr, 64'h100);
    tick();
    chk_buf("f1", 64'h100);
    chk("f1_addr", imem_addr, 64'h104);
    tick();
    chk_buf("f2", 64'h104);
    chk("f2_addr", imem_addr, 64'h108);
    tick();
    chk_buf("f3", 64'h108);
    instr_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 64'(imem_req), 0);
      chk_buf("stall", 64'h108);
      tick();
    end
    instr_ready = 1'b1;
    #1;
    chk("unstall_addr", imem_addr, 64'h10C);
    tick();
    chk_buf("nogap", 64'h10C);
    resolve(64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
    tick();
    resolve_valid = 1'b0;
    chk("b_valid", 64'(instr_valid), 0);
    chk("b_addr", imem_addr, 64'h1F8);
    chk("b_cnt", 64'(redirect_count), 1);
    tick();
    chk_buf("b_tgt", 64'h1F8);
    resolve(64'h40, 64'd3, 1'b0, 1'b1, 1'b0);
    tick();
    chk("cbz_nt_cnt", 64'(redirect_count), 1);
    chk_buf("cbz_nt", 64'h1FC);
    resolve(64'h40, 64'd3, 1'b0, 1'b1, 1'b1);
    tick();
    resolve_valid = 1'b0;
    chk("cbz_cnt", 64'(redirect_count), 2);
    chk("cbz_addr", imem_addr, 64'h4C);
    chk("cbz_valid", 64'(instr_valid), 0);
    tick();
    chk_buf("cbz_tgt", 64'h4C);
    resolve(64'h120, 64'd0, 1'b1, 1'b0, 1'b0);
    tick();
    resolve_valid = 1'b0;
    imem_ready = 1'b0;
    chk("j120_addr", imem_addr, 64'h120);
    tick();
    chk("st_addr", imem_addr, 64'h120);
    resolve(64'h300, 64'd0, 1'b1, 1'b0, 1'b0);
    tick();
    resolve_valid = 1'b0;
    chk("dr_cnt", 64'(redirect_count), 4);
    for (int i = 0; i < 3; i++) begin
      chk("dr_req", 64'(imem_req), 1);
      chk("dr_addr", imem_addr, 64'h120);
      chk("dr_valid", 64'(instr_valid), 0);
      if (i < 2) tick();
    end
    imem_ready = 1'b1;
    tick();
    chk("post_dr_addr", imem_addr, 64'h300);
    chk("post_dr_valid", 64'(instr_valid), 0);
    tick();
    chk_buf("t300", 64'h300);
    imem_ready = 1'b0;
    resolve(64'h500, 64'd0, 1'b1, 1'b0, 1'b0);
    tick();
    resolve_valid = 1'b0;
    chk("dr2_addr", imem_addr, 64'h304);
    chk("dr2_req", 64'(imem_req), 1);
    chk("dr2_cnt", 64'(redirect_count), 5);
    #2;
    resetl = 1'b0;
    #1;
    chk("arst_req", 64'(imem_req), 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_valid", 64'(instr_valid), 0);
    chk("arst_instr", 64'(instr), 0);
    chk("arst_ipc", instr_pc, 0);
    chk("arst_cnt", 64'(redirect_count), 0);
    startpc = 64'h80;
    imem_ready = 1'b1;
    resetl = 1'b1;
    #1;
    chk("reboot_req", 64'(imem_req), 0);
    tick();
    chk("reboot_addr", imem_addr, 64'h80);
    tick();
    chk_buf("reboot", 64'h80);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Owns the PC and issues requests to instruction memory over a ready handshake.
- Buffers one fetched instruction and presents it, its PC and its 11-bit opcode field (instr[31:21]) to decode over a valid/ready handshake.
- Applies redirects from branch resolution (B, CBZ) and discards stale or in-flight fetches.

Parameters:
- XLEN, 64, address/PC width.
- ILEN, 32, instruction width.
- CNT_W, 32, width of the redirect performance counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- resetl  input  1  asynchronous active-low reset.
- startpc  input  XLEN  boot PC, sampled in the BOOT state.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; held stable while imem_req=1 and imem_ready=0.
- imem_ready  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  input  ILEN  fetched instruction word.
- instr_valid  output  1  output buffer holds an instruction.
- instr_ready  input  1  decode accepts the buffered instruction.
- instr  output  ILEN  buffered instruction.
- instr_pc  output  XLEN  PC of the buffered instruction.
- opcode  output  11  instr[31:21], fed straight to the control decoder.
- resolve_valid  input  1  branch resolution information is valid this cycle.
- resolve_pc  input  XLEN  PC of the resolving instruction.
- resolve_extimm  input  XLEN  sign-extended branch offset, in words.
- branch  input  1  conditional-branch control bit.
- uncond_branch  input  1  unconditional-branch control bit.
- zero  input  1  ALU zero flag.
- redirect_count  output  CNT_W  number of taken redirects; wraps.

Behaviour:
- Reset (resetl=0, asynchronous) sets:
  - pc=0, state=BOOT;
  - imem_req=0, imem_addr=0;
  - instr_valid=0, instr=0, instr_pc=0, opcode=0;
  - redirect_count=0.
- Redirect condition: redirect = resolve_valid & (uncond_branch | (branch & zero)). Inputs are evaluated only when resolve_valid=1, so X values are tolerated otherwise.
- Target: target = resolve_pc + (resolve_extimm << 2), truncated to XLEN. The sum wraps modulo 2^XLEN.
- States:
  - BOOT: imem_req=0. Next edge: pc<=startpc, go to FETCH. A redirect in BOOT is ignored.
  - FETCH:
    - imem_req = (~instr_valid | instr_ready); imem_addr = pc.
    - Request accepted (imem_req & imem_ready) with no redirect: buffer <= {imem_rdata, pc}, instr_valid<=1, pc<=pc+4. Zero-bubble back-to-back fetch is allowed when decode accepts in the same cycle.
    - Decode accepts and no new capture: instr_valid<=0.
    - Redirect with imem_req=1 and imem_ready=0 (request in flight): pc<=target, instr_valid<=0, go to DRAIN.
    - Redirect otherwise: pc<=target, instr_valid<=0, stay in FETCH. Any imem_rdata arriving that cycle is discarded.
  - DRAIN:
    - imem_req=1, and imem_addr holds the old address latched at redirect until imem_ready=1.
    - On imem_ready the data is discarded; go to FETCH, which requests from pc (= target).
    - A further redirect in DRAIN updates pc to the new target and stays in DRAIN.
- Priority: redirect > capture > plain consume. instr_ready in the redirect cycle still completes that handshake; the buffer is then cleared.
- imem_addr must not change while imem_req=1 and imem_ready=0, including across a redirect (hence DRAIN).
- Output buffer has exactly one entry. instr, instr_pc and opcode are stable while instr_valid=1 and instr_ready=0.
- redirect_count increments by 1 on every cycle where redirect=1 (BOOT excluded) and wraps at 2^CNT_W.
- Latency: an accepted memory response is visible at the outputs on the next edge (1 cycle).
- Reset mid-fetch abandons the request immediately. imem_req drops asynchronously, with no drain.

Decomposition:
- Shared package fetch_pkg:
  - state encoding: BOOT=2'd0, FETCH=2'd1, DRAIN=2'd2;
  - XLEN/ILEN defaults;
  - OPCODE_MSB=31, OPCODE_LSB=21;
  - PC_INC=4.
- Sub-module next_pc_calc: combinational target adder plus the redirect condition (inputs resolve_pc, resolve_extimm, branch, uncond_branch, zero, resolve_valid; outputs target, redirect). Reused by the single-cycle datapath.

Test Plan:
- Reset, then release with startpc=0x100 and imem_ready tied to 1 -> imem_addr sequence 0x100, 0x104, 0x108; instr_pc matches; opcode=imem_rdata[31:21]; no request during BOOT.
- instr_ready held low for 3 cycles with instr_valid=1 -> imem_req=0, instr/instr_pc/opcode stable; one cycle after instr_ready=1, the next word appears with no gap.
- resolve_valid=1, uncond_branch=1, resolve_pc=0x200, resolve_extimm=-2 -> pc=0x1F8, instr_valid=0 next cycle, next imem_addr=0x1F8, redirect_count=1.
- CBZ case with branch=1: zero=0 -> no redirect and counter unchanged; zero=1 with extimm=3 from 0x40 -> target 0x4C.
- Redirect to 0x300 while a request to 0x120 is stalled (imem_ready=0 for 4 cycles) -> imem_addr stays 0x120 until ready, that data is never presented, next request is to 0x300.
- resetl pulsed low mid-DRAIN -> all outputs 0 asynchronously; after release, the fetch restarts from startpc.
